fetch_sequencer: RTL

- Sequences the 8-bit instruction memory: it drives the address and captures the instruction the memory returns in the same cycle.
- Owns the program counter, boots from the reset vector (mem[0]), enters the interrupt vector (mem[1]) on request, and applies branch redirects.
- Presents one fetched instruction at a time to the decode stage through a valid/ready output register.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 51 +++++
 rtl/fetch_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, vector locations and fetch FSM states.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00;
    localparam logic [ADDR_W-1:0] INT_VEC_ADDR   = 8'h01;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        INTVEC = 2'd1,
        FETCH  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_if
// Brief    : Instruction-memory, decode, redirect and interrupt signals of the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_sequencer_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              int_req;
    logic              int_ack;
    logic [ADDR_W-1:0] int_ret_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        input  redirect_valid,
        input  redirect_pc,
        input  int_req,
        output int_ack,
        output int_ret_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        output redirect_valid,
        output redirect_pc,
        output int_req,
        input  int_ack,
        input  int_ret_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner; boots/vectors from memory and feeds decode via a valid/ready register.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int                ADDR_W         = cpu_pkg::ADDR_W,
    parameter int                DATA_W         = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
    parameter logic [ADDR_W-1:0] INT_VEC_ADDR   = cpu_pkg::INT_VEC_ADDR
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fetch_sequencer_if.master bus
);
    import cpu_pkg::*;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_if_valid, w_if_valid_nxt;
    logic [DATA_W-1:0] r_if_instr, w_if_instr_nxt;
    logic [ADDR_W-1:0] r_if_pc, w_if_pc_nxt;
    logic [ADDR_W-1:0] w_imem_addr;
    logic [ADDR_W-1:0] w_ret_pc;
    logic              w_slot_free;
    logic              w_take_int;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_imem_addr    = r_pc;
        w_ret_pc       = '0;
        w_take_int     = 1'b0;
        w_slot_free    = !r_if_valid || bus.if_ready;

        case (r_state)
            BOOT: begin
                w_imem_addr = RESET_VEC_ADDR;
                w_pc_nxt    = ADDR_W'(bus.imem_data);
                w_state_nxt = FETCH;
            end
            INTVEC: begin
                w_imem_addr = INT_VEC_ADDR;
                w_pc_nxt    = ADDR_W'(bus.imem_data);
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt       = bus.redirect_pc;
                    w_if_valid_nxt = 1'b0;
                end else if (bus.int_req) begin
                    // A stalled instruction is flushed, so resume must refetch it.
                    w_take_int     = !rst;
                    w_ret_pc       = (r_if_valid && !bus.if_ready) ? r_if_pc : r_pc;
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = INTVEC;
                end else if (w_slot_free) begin
                    w_if_instr_nxt = bus.imem_data;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= '0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
        end
    end

    assign bus.imem_addr  = w_imem_addr;
    assign bus.if_valid   = r_if_valid;
    assign bus.if_instr   = r_if_instr;
    assign bus.if_pc      = r_if_pc;
    assign bus.int_ack    = w_take_int;
    assign bus.int_ret_pc = w_take_int ? w_ret_pc : '0;

endmodule
`default_nettype wire
